life_run_ctrl: RTL and testbench
================================

// Module: life_run_ctrl
// PURPOSE
//  Run controller for the 16x16 Game-of-Life generation datapath (dpgen). It loads the seed,
//  clears the grid and issues one-cycle generation-advance strobes at a programmable rate.
//  It supports free-run, pause and single-step, counts generations and halts automatically
//  on extinction, still-life or a generation limit. It sits between host/top-level controls and dpgen.
// PARAMETERS
//  GRID_N  256  grid bits (16x16); bit 16*r+c = cell (r,c)
//  GEN_W   16   generation counter width
//  DIV_W   24   rate divider width
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       synchronous, active-high
//  start        in   1       pulse: load seed (if seed_load) and begin free-run
//  stop         in   1       pulse: pause after any in-flight step
//  step         in   1       pulse: advance exactly one generation while PAUSED
//  clear        in   1       pulse: zero grid, counters; go IDLE
//  seed_load    in   1       level: start loads seed before running
//  rate_div     in   DIV_W   cycles between steps minus 1; sampled on every divider reload
//  max_gen      in   GEN_W   generation limit; 0 = unlimited
//  grid_cur     in   GRID_N  dpgen current-state register
//  grid_next    in   GRID_N  dpgen combinational next state
//  dp_load      out  1       load seed into dpgen
//  dp_step      out  1       dpgen advances one generation on this edge
//  dp_clear     out  1       zero dpgen grid
//  gen_count    out  GEN_W   generations completed since load/clear
//  running      out  1       high in RUN_WAIT/STEP
//  done         out  1       high in HALT
//  halt_reason  out  2       00 none, 01 still-life, 10 extinct, 11 max_gen
// BEHAVIOUR
//  - All outputs are registered. Reset: state=IDLE, all strobes 0, gen_count=0, halt_reason=00.
//  - States: IDLE, LOAD, RUN_WAIT, STEP, PAUSED, HALT.
//  - Command priority per cycle: reset > clear > stop > start > step. Lower-priority commands are dropped.
//  - IDLE/PAUSED/HALT + start: if seed_load, go to LOAD (dp_load=1 for 1 cycle, gen_count:=0,
//    halt_reason:=00), then RUN_WAIT. Otherwise go straight to RUN_WAIT.
//    start from HALT without seed_load re-halts at the next check if the condition still holds.
//  - RUN_WAIT: divider loads rate_div on entry and counts down to 0. At 0, run the halt check:
//    extinct if grid_cur==0; else still-life if grid_next==grid_cur; else max if
//    max_gen!=0 && gen_count==max_gen. Any hit -> HALT with that halt_reason, no dp_step.
//    Otherwise -> STEP.
//  - STEP: dp_step=1 for exactly one cycle, gen_count+1 (saturates at all-ones), then RUN_WAIT.
//    rate_div=0 gives one step every 2 cycles. rate_div=k gives one step every k+2 cycles.
//  - stop in RUN_WAIT -> PAUSED, divider discarded. stop in STEP: the strobe completes, then PAUSED.
//  - PAUSED + step: run the halt check. Pass -> one dp_step, gen_count+1, back to PAUSED.
//    Fail -> HALT.
//  - clear (any state except reset): dp_clear=1 for one cycle, gen_count:=0, halt_reason:=00, IDLE.
//  - dp_load, dp_step and dp_clear are mutually exclusive; never two in one cycle.
//  - Reset mid-run: no strobe is emitted on the reset cycle or the cycle after.
//  - start while already running is ignored. step outside PAUSED is ignored.
// STRUCTURE
//  - life_pkg: GRID_N; typedef enum ctrl_state_t {IDLE,LOAD,RUN_WAIT,STEP,PAUSED,HALT};
//    typedef enum logic[1:0] halt_t {H_NONE,H_STILL,H_EXTINCT,H_MAX}.
//  - Sub-module life_tick_div: DIV_W down-counter with load/enable and a zero flag.
//  - The FSM, halt comparators and gen counter live in life_run_ctrl.
// TESTING (bench instantiates dpgen + life_run_ctrl; 10 ns clock)
//  - Seed 2x2 block at bits {0,1,16,17}, seed_load=1, start, rate_div=0 -> dp_load once,
//    no dp_step, HALT, halt_reason=01, gen_count=0.
//  - Blinker bits {17,18,19}, max_gen=4, rate_div=3 -> dp_step every 5 cycles, exactly 4 strobes,
//    halt_reason=11, gen_count=4.
//  - Single cell bit 0 -> one dp_step, gen_count=1, then halt_reason=10. grid_cur=0.
//  - Blinker run, stop after 2 steps -> PAUSED. Three step pulses -> gen_count=5,
//    grid matches vertical blinker.
//  - start and clear in the same cycle -> clear wins: dp_clear=1, IDLE, gen_count=0, no dp_load.
//  - reset asserted 2 cycles into RUN_WAIT -> IDLE next edge, all outputs at reset values,
//    no dp_step for 2 cycles.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants, state/halt types and the halt-check helper for the
// Game-of-Life run controller.
package life_pkg;

  localparam int GRID_N = 256;
  localparam int GEN_W  = 16;
  localparam int DIV_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN_WAIT,
    STEP,
    PAUSED,
    HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    H_NONE    = 2'b00,
    H_STILL   = 2'b01,
    H_EXTINCT = 2'b10,
    H_MAX     = 2'b11
  } halt_t;

  // Extinction outranks still-life (an empty grid is trivially still).
  function automatic halt_t halt_check(input logic [GRID_N-1:0] cur,
                                       input logic [GRID_N-1:0] nxt,
                                       input logic [GEN_W-1:0]  gen,
                                       input logic [GEN_W-1:0]  lim);
    if (cur == '0) return H_EXTINCT;
    if (nxt == cur) return H_STILL;
    if ((lim != '0) && (gen == lim)) return H_MAX;
    return H_NONE;
  endfunction

  function automatic logic [GEN_W-1:0] gen_sat_inc(input logic [GEN_W-1:0] g);
    return (g == '1) ? g : g + GEN_W'(1);
  endfunction

endpackage

// File: rtl/life_tick_div.sv
// Step-rate divider: loads a reload value, counts down to zero and holds there.
module life_tick_div
  import life_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/life_run_ctrl.sv
// Run controller for the 16x16 Life datapath: seed load, clear, rate-paced
// generation strobes, pause/single-step and automatic halt detection.
//
// state    | meaning
// IDLE     | nothing loaded or just cleared; waiting for start
// LOAD     | dp_load strobe, seed enters dpgen
// RUN_WAIT | free-run, divider counting down; halt check at zero
// STEP     | dp_step strobe, one generation advances
// PAUSED   | halted by stop; step pulses advance singly
// HALT     | extinct / still-life / generation limit reached
module life_run_ctrl
  import life_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              clear,
  input  logic              seed_load,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [GEN_W-1:0]  max_gen,
  input  logic [GRID_N-1:0] grid_cur,
  input  logic [GRID_N-1:0] grid_next,
  output logic              dp_load,
  output logic              dp_step,
  output logic              dp_clear,
  output logic [GEN_W-1:0]  gen_count,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_reason
);

  ctrl_state_t      state_q, state_d;
  halt_t            reason_q, reason_d, chk_res;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             single_q, single_d;
  logic             launch;
  logic             div_load, div_en, div_zero;
  logic             dp_load_q, dp_step_q, dp_clear_q, running_q, done_q;

  life_tick_div u_div (
    .clk       (clk),
    .reset     (reset),
    .load_i    (div_load),
    .en_i      (div_en),
    .load_val_i(rate_div),
    .zero_o    (div_zero)
  );

  assign chk_res = halt_check(grid_cur, grid_next, gen_q, max_gen);
  assign div_en  = (state_q == RUN_WAIT);

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    gen_d    = gen_q;
    single_d = single_q;
    launch   = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      reason_d = H_NONE;
      gen_d    = '0;
      single_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: launch = start && !stop;
        LOAD:       state_d = stop ? PAUSED : RUN_WAIT;
        RUN_WAIT: begin
          if (stop) begin
            state_d = PAUSED;
          end else if (div_zero) begin
            if (chk_res != H_NONE) begin
              state_d  = HALT;
              reason_d = chk_res;
            end else begin
              state_d  = STEP;
              single_d = 1'b0;
            end
          end
        end
        STEP: begin
          gen_d   = gen_sat_inc(gen_q);
          state_d = (stop || single_q) ? PAUSED : RUN_WAIT;
        end
        PAUSED: begin
          if (!stop) begin
            if (start) begin
              launch = 1'b1;
            end else if (step) begin
              if (chk_res != H_NONE) begin
                state_d  = HALT;
                reason_d = chk_res;
              end else begin
                state_d  = STEP;
                single_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (launch) begin
        if (seed_load) begin
          state_d  = LOAD;
          gen_d    = '0;
          reason_d = H_NONE;
        end else begin
          state_d = RUN_WAIT;
        end
      end
    end
  end

  // Reload on every entry so a stop discards the partial count.
  assign div_load = (state_d == RUN_WAIT) && (state_q != RUN_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      reason_q   <= H_NONE;
      gen_q      <= '0;
      single_q   <= 1'b0;
      dp_load_q  <= 1'b0;
      dp_step_q  <= 1'b0;
      dp_clear_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reason_q   <= reason_d;
      gen_q      <= gen_d;
      single_q   <= single_d;
      dp_load_q  <= (state_d == LOAD);
      dp_step_q  <= (state_d == STEP);
      dp_clear_q <= clear;
      running_q  <= (state_d == RUN_WAIT) || (state_d == STEP);
      done_q     <= (state_d == HALT);
    end
  end

  assign dp_load     = dp_load_q;
  assign dp_step     = dp_step_q;
  assign dp_clear    = dp_clear_q;
  assign gen_count   = gen_q;
  assign running     = running_q;
  assign done        = done_q;
  assign halt_reason = reason_q;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Scoreboard bench for life_run_ctrl with a behavioural dpgen and an
// event-level reference model of the run controller.
module tb_life_run_ctrl;
  import life_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, stop, step, clear, seed_load;
  logic [DIV_W-1:0]  rate_div;
  logic [GEN_W-1:0]  max_gen;
  logic [GRID_N-1:0] grid_cur, grid_next, seed;
  logic              dp_load, dp_step, dp_clear, running, done;
  logic [GEN_W-1:0]  gen_count;
  logic [1:0]        halt_reason;

  life_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .clear(clear), .seed_load(seed_load), .rate_div(rate_div), .max_gen(max_gen),
    .grid_cur(grid_cur), .grid_next(grid_next), .dp_load(dp_load), .dp_step(dp_step),
    .dp_clear(dp_clear), .gen_count(gen_count), .running(running), .done(done),
    .halt_reason(halt_reason)
  );

  function automatic logic [GRID_N-1:0] life_next(input logic [GRID_N-1:0] g);
    logic [GRID_N-1:0] n;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              cnt += int'(g[16 * (r + dr) + c + dc]);
        n[16 * r + c] = (cnt == 3) || (g[16 * r + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Behavioural dpgen.
  assign grid_next = life_next(grid_cur);
  always @(posedge clk) begin
    if (reset)         grid_cur <= '0;
    else if (dp_clear) grid_cur <= '0;
    else if (dp_load)  grid_cur <= seed;
    else if (dp_step)  grid_cur <= grid_next;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [GRID_N-1:0] act, input logic [GRID_N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard events
  localparam int EV_LOAD = 0, EV_STEP = 1, EV_CLEAR = 2, EV_HALT = 3;
  typedef struct { int kind; int cyc; int gen; int reason; } ev_t;
  ev_t exp_q[$];

  task automatic push_ev(input int kind, input int c, input int g, input int r);
    ev_t e;
    e.kind = kind; e.cyc = c; e.gen = g; e.reason = r;
    exp_q.push_back(e);
  endtask

  // Reference model: modes plus the strobe currently on the outputs.
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_PAUSE = 2, MD_HALT = 3;
  localparam int SH_NONE = 0, SH_LOAD = 1, SH_STEP = 2, SH_CLEAR = 3;
  int                m_mode = MD_IDLE, m_shown = SH_NONE, m_chk = 0, m_gen = 0, m_reason = 0;
  bit                m_single = 1'b0;
  logic [GRID_N-1:0] m_grid = '0;

  function automatic int model_halt();
    if (m_grid == '0) return 2;
    if (life_next(m_grid) == m_grid) return 1;
    if (max_gen != 0 && m_gen == int'(max_gen)) return 3;
    return 0;
  endfunction

  task automatic launch(input int c);
    if (seed_load) begin
      m_gen = 0; m_reason = 0; m_shown = SH_LOAD;
      push_ev(EV_LOAD, c, 0, 0);
    end else begin
      m_mode = MD_RUN;
      m_chk  = c + int'(rate_div) + 1;
    end
  endtask

  task automatic try_step(input int c, input bit single);
    int r;
    r = model_halt();
    if (r != 0) begin
      m_reason = r; m_mode = MD_HALT;
      push_ev(EV_HALT, c, m_gen, r);
    end else begin
      push_ev(EV_STEP, c, m_gen, m_reason);
      m_shown = SH_STEP; m_single = single;
    end
  endtask

  // Predicts what the outputs show after clock edge number c.
  task automatic model_edge(input int c);
    int prev;
    if (reset) begin
      m_mode = MD_IDLE; m_shown = SH_NONE; m_single = 1'b0;
      m_gen = 0; m_reason = 0; m_grid = '0;
      return;
    end
    case (m_shown)
      SH_LOAD:  m_grid = seed;
      SH_STEP:  begin m_grid = life_next(m_grid); if (m_gen < 65535) m_gen++; end
      SH_CLEAR: m_grid = '0;
      default:  ;
    endcase
    prev = m_shown;
    m_shown = SH_NONE;
    if (clear) begin
      m_gen = 0; m_reason = 0; m_mode = MD_IDLE; m_shown = SH_CLEAR;
      push_ev(EV_CLEAR, c, 0, 0);
      return;
    end
    if (prev == SH_LOAD || prev == SH_STEP) begin
      if (stop || (prev == SH_STEP && m_single)) m_mode = MD_PAUSE;
      else begin m_mode = MD_RUN; m_chk = c + int'(rate_div) + 1; end
      return;
    end
    case (m_mode)
      MD_IDLE, MD_HALT: if (!stop && start) launch(c);
      MD_PAUSE: if (!stop) begin
        if (start) launch(c);
        else if (step) try_step(c, 1'b1);
      end
      MD_RUN: begin
        if (stop) m_mode = MD_PAUSE;
        else if (c == m_chk) try_step(c, 1'b0);
      end
      default: ;
    endcase
  endtask

  // Monitor
  int n_load = 0, n_step = 0, n_clear = 0;
  int step_cyc_q[$];
  logic done_d = 1'b0;

  always @(negedge clk) begin : mon
    int k, nstr;
    ev_t e;
    k = -1;
    nstr = int'(dp_load) + int'(dp_step) + int'(dp_clear);
    if (dp_clear) begin k = EV_CLEAR; n_clear++; end
    if (dp_step)  begin k = EV_STEP;  n_step++; step_cyc_q.push_back(cyc); end
    if (dp_load)  begin k = EV_LOAD;  n_load++; end
    if (k < 0 && done === 1'b1 && done_d !== 1'b1) k = EV_HALT;
    if (nstr > 1) chk("strobe_exclusive", nstr, 1);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL sb_missing: expected kind %0d at cycle %0d, not observed", exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (k >= 0) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected: got kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind", k, e.kind);
        chk("sb_gen", gen_count, e.gen);
        chk("sb_reason", halt_reason, e.reason);
      end
    end
    done_d = done;
  end

  // Stimulus
  logic [GRID_N-1:0] nx_seed = '0;
  logic              nx_seed_load = 1'b0;
  logic [DIV_W-1:0]  nx_rate = '0;
  logic [GEN_W-1:0]  nx_max = '0;

  task automatic drive(input bit st, input bit sp, input bit sk, input bit cl, input bit rs);
    @(negedge clk);
    start = st; stop = sp; step = sk; clear = cl; reset = rs;
    seed = nx_seed; seed_load = nx_seed_load; rate_div = nx_rate; max_gen = nx_max;
    model_edge(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [GRID_N-1:0] bits3(input int a, input int b, input int c);
    logic [GRID_N-1:0] g;
    g = '0; g[a] = 1'b1; g[b] = 1'b1; g[c] = 1'b1;
    return g;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [GRID_N-1:0] blk, blinker_h, blinker_v, g;
    int l0, s0, c0;
    blk = bits3(0, 1, 16); blk[17] = 1'b1;
    blinker_h = bits3(17, 18, 19);
    blinker_v = bits3(2, 18, 34);
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
    seed_load = 1'b0; rate_div = '0; max_gen = '0; seed = '0;

    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("rst_gen", gen_count, 0);
    chk("rst_reason", halt_reason, 0);
    chk("rst_flags", {running, done, dp_load, dp_step, dp_clear}, 0);
    idle(2);

    // Still-life block halts before any step
    nx_seed = blk; nx_seed_load = 1'b1; nx_rate = 0; nx_max = 0;
    l0 = n_load; s0 = n_step;
    drive(1, 0, 0, 0, 0); idle(8);
    chk("blk_done", done, 1);
    chk("blk_reason", halt_reason, 1);
    chk("blk_gen", gen_count, 0);
    chk("blk_loads", n_load - l0, 1);
    chk("blk_steps", n_step - s0, 0);

    // Blinker with generation limit 4, rate 3
    drive(0, 0, 0, 1, 0); idle(1);
    nx_seed = blinker_h; nx_rate = 3; nx_max = 4;
    s0 = n_step; step_cyc_q.delete();
    drive(1, 0, 0, 0, 0); idle(40);
    chk("lim_steps", n_step - s0, 4);
    chk("lim_reason", halt_reason, 3);
    chk("lim_gen", gen_count, 4);
    chk("lim_period", (step_cyc_q.size() == 4) ? step_cyc_q[3] - step_cyc_q[0] : -1, 15);
    chk("lim_grid", grid_cur, blinker_h);

    // Single cell dies after one step
    drive(0, 0, 0, 1, 0); idle(1);
    g = '0; g[0] = 1'b1;
    nx_seed = g; nx_rate = 0; nx_max = 0;
    s0 = n_step;
    drive(1, 0, 0, 0, 0); idle(10);
    chk("ext_steps", n_step - s0, 1);
    chk("ext_gen", gen_count, 1);
    chk("ext_reason", halt_reason, 2);
    chk("ext_grid", grid_cur, 0);

    // Stop after two steps, then three single steps
    drive(0, 0, 0, 1, 0); idle(1);
    nx_seed = blinker_h; nx_rate = 3; nx_max = 0;
    s0 = n_step;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 100 && (n_step - s0) < 2; i++) idle(1);
    chk("pause_wait_two", n_step - s0, 2);
    drive(0, 1, 0, 0, 0); idle(8);
    chk("pause_steps", n_step - s0, 2);
    chk("pause_flags", {running, done}, 0);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0); idle(3); end
    chk("pause_gen", gen_count, 5);
    chk("pause_grid", grid_cur, blinker_v);
    chk("pause_running", running, 0);

    // start and clear together: clear wins
    l0 = n_load; c0 = n_clear;
    drive(1, 0, 0, 1, 0); idle(3);
    chk("sc_clears", n_clear - c0, 1);
    chk("sc_loads", n_load - l0, 0);
    chk("sc_gen", gen_count, 0);
    chk("sc_flags", {running, done}, 0);
    chk("sc_grid", grid_cur, 0);

    // Reset two cycles into RUN_WAIT
    nx_seed = blinker_h; nx_rate = 20; nx_max = 0;
    drive(1, 0, 0, 0, 0); idle(2);
    chk("mr_running", running, 1);
    drive(0, 0, 0, 0, 1); idle(1);
    s0 = n_step;
    chk("mr_gen", gen_count, 0);
    chk("mr_reason", halt_reason, 0);
    chk("mr_flags", {running, done, dp_load, dp_step, dp_clear}, 0);
    idle(1);
    chk("mr_nostep", {dp_step, 8'(n_step - s0)}, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: begin g = '0; for (int b = 0; b < GRID_N; b++) g[b] = ($urandom_range(0, 3) == 0); end
          1: g = blinker_h;
          2: g = blk;
          default: begin g = bits3(1, 18, 32); g[33] = 1'b1; g[34] = 1'b1; end
        endcase
        nx_seed = g;
        nx_seed_load = ($urandom_range(0, 3) != 0);
        nx_rate = DIV_W'($urandom_range(0, 5));
        nx_max  = GEN_W'($urandom_range(0, 10));
      end
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 299) == 0);
    end
    drive(0, 1, 0, 0, 0); idle(10);
    chk("rnd_gen", gen_count, m_gen);
    chk("rnd_reason", halt_reason, m_reason);
    chk("rnd_grid", grid_cur, m_grid);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
